// File: rtl/branch_resolve_queue_if.sv
// Dispatch-side op bus and resolve-side result bus of branch_resolve_queue.
// slave = resolution unit view, master = producer/consumer view.
interface branch_resolve_queue_if #(
    parameter int unsigned VLEN = 64
);
    logic            valid_i;
    logic            ready_o;
    logic [1:0]      op_i;
    logic [VLEN-1:0] pc_i;
    logic [VLEN-1:0] operand_a_i;
    logic [VLEN-1:0] imm_i;
    logic            cmp_res_i;
    logic            is_compressed_i;
    logic            pred_taken_i;
    logic [VLEN-1:0] pred_addr_i;
    logic [VLEN-1:0] pcc_base_i;
    logic [VLEN:0]   pcc_top_i;

    logic            res_valid_o;
    logic            res_ready_i;
    logic [VLEN-1:0] res_pc_o;
    logic [VLEN-1:0] res_target_o;
    logic [VLEN-1:0] res_link_o;
    logic            res_taken_o;
    logic            res_mispredict_o;
    logic [1:0]      res_exc_o;

    modport slave (
        input  valid_i, op_i, pc_i, operand_a_i, imm_i, cmp_res_i, is_compressed_i,
               pred_taken_i, pred_addr_i, pcc_base_i, pcc_top_i, res_ready_i,
        output ready_o, res_valid_o, res_pc_o, res_target_o, res_link_o,
               res_taken_o, res_mispredict_o, res_exc_o
    );

    modport master (
        output valid_i, op_i, pc_i, operand_a_i, imm_i, cmp_res_i, is_compressed_i,
               pred_taken_i, pred_addr_i, pcc_base_i, pcc_top_i, res_ready_i,
        input  ready_o, res_valid_o, res_pc_o, res_target_o, res_link_o,
               res_taken_o, res_mispredict_o, res_exc_o
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// Branch resolution unit with a DEPTH-entry result FIFO and saturating mispredict counter.
// Define CHERI_PCC_BOUNDS_EN to enable PCC bounds exceptions (exc=2) on taken targets.
module branch_resolve_queue #(
    parameter int unsigned VLEN  = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RVC   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    branch_resolve_queue_if.slave bus,
    output logic [CNT_W-1:0]     mispredict_cnt_o
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned VW1 = VLEN + 1;

    typedef enum logic [1:0] {
        OP_BRANCH = 2'd0,
        OP_JAL    = 2'd1,
        OP_JALR   = 2'd2,
        OP_NOP    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        EXC_NONE       = 2'd0,
        EXC_MISALIGNED = 2'd1,
        EXC_BOUNDS     = 2'd2,
        EXC_RSVD       = 2'd3
    } exc_e;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
        logic [VLEN-1:0] link;
        logic            taken;
        logic            mispredict;
        logic [1:0]      exc;
    } entry_t;

    op_e             op;
    logic [VLEN-1:0] base;
    logic [VLEN-1:0] link;
    logic [VLEN-1:0] tgt;
    logic            taken;
    logic            mispredict;
    exc_e            exc;
    entry_t          entry_d;

    logic            accept;
    logic            push;
    logic            pop;
    logic            res_valid;
    entry_t          head;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign op = op_e'(bus.op_i);

`ifdef CHERI_PCC_BOUNDS_EN
    logic [VLEN:0] tgt_p2;
    assign tgt_p2 = {1'b0, tgt} + VW1'(2);
`else
    logic unused_pcc;
    assign unused_pcc = ^{bus.pcc_base_i, bus.pcc_top_i};
`endif

    always_comb begin
        base       = (op == OP_JALR) ? bus.operand_a_i : bus.pc_i;
        link       = bus.pc_i + (bus.is_compressed_i ? VLEN'(2) : VLEN'(4));
        tgt        = base + bus.imm_i;
        taken      = 1'b1;
        mispredict = 1'b0;
        exc        = EXC_NONE;

        if (op == OP_JALR) begin
            tgt[0] = 1'b0;
        end

        case (op)
            OP_BRANCH: begin
                taken      = bus.cmp_res_i;
                mispredict = (bus.cmp_res_i != bus.pred_taken_i);
            end
            OP_JAL:  mispredict = !bus.pred_taken_i;
            OP_JALR: mispredict = !bus.pred_taken_i || (tgt != bus.pred_addr_i);
            default: mispredict = 1'b0;
        endcase

        // Misaligned outranks bounds; neither applies to a fall-through.
        if (taken) begin
            if (tgt[0] || ((RVC == 0) && tgt[1])) begin
                exc = EXC_MISALIGNED;
            end
`ifdef CHERI_PCC_BOUNDS_EN
            else if ((tgt < bus.pcc_base_i) || (tgt_p2 > bus.pcc_top_i)) begin
                exc = EXC_BOUNDS;
            end
`endif
        end

        entry_d.pc         = bus.pc_i;
        entry_d.target     = taken ? tgt : link;
        entry_d.link       = link;
        entry_d.taken      = taken;
        entry_d.mispredict = mispredict;
        entry_d.exc        = exc;
    end

    assign bus.ready_o = (count_q != CW'(DEPTH));
    assign res_valid   = (count_q != '0);
    assign accept      = bus.valid_i && bus.ready_o && !flush_i;
    assign push        = accept && (op != OP_NOP);
    assign pop         = res_valid && bus.res_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cnt_d    = cnt_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end

        // Reserved ops carry mispredict=0, so they never bump the counter.
        if (accept && mispredict && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    assign head = res_valid ? mem_q[rd_ptr_q] : '0;

    assign bus.res_valid_o      = res_valid;
    assign bus.res_pc_o         = head.pc;
    assign bus.res_target_o     = head.target;
    assign bus.res_link_o       = head.link;
    assign bus.res_taken_o      = head.taken;
    assign bus.res_mispredict_o = head.mispredict;
    assign bus.res_exc_o        = head.exc;
    assign mispredict_cnt_o     = cnt_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (RVC=1 main instance,
// RVC=0 / CNT_W=2 side instance fed the same ops with an always-ready consumer).
module tb_branch_resolve_queue;
    localparam int unsigned VLEN = 64;

    logic clk;
    logic rst_n;
    logic flush;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    branch_resolve_queue_if #(.VLEN(VLEN)) bus0 ();
    branch_resolve_queue_if #(.VLEN(VLEN)) bus1 ();

    branch_resolve_queue #(.VLEN(VLEN), .DEPTH(4), .RVC(1), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus0), .mispredict_cnt_o(cnt0)
    );

    branch_resolve_queue #(.VLEN(VLEN), .DEPTH(4), .RVC(0), .CNT_W(2)) u_dut_norvc (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus1), .mispredict_cnt_o(cnt1)
    );

    assign bus1.valid_i         = bus0.valid_i;
    assign bus1.op_i            = bus0.op_i;
    assign bus1.pc_i            = bus0.pc_i;
    assign bus1.operand_a_i     = bus0.operand_a_i;
    assign bus1.imm_i           = bus0.imm_i;
    assign bus1.cmp_res_i       = bus0.cmp_res_i;
    assign bus1.is_compressed_i = bus0.is_compressed_i;
    assign bus1.pred_taken_i    = bus0.pred_taken_i;
    assign bus1.pred_addr_i     = bus0.pred_addr_i;
    assign bus1.pcc_base_i      = bus0.pcc_base_i;
    assign bus1.pcc_top_i       = bus0.pcc_top_i;
    assign bus1.res_ready_i     = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [63:0] pc, input logic [63:0] a,
                         input logic [63:0] imm, input logic cmp, input logic c,
                         input logic pt, input logic [63:0] pa);
        bus0.valid_i         = 1'b1;
        bus0.op_i            = op;
        bus0.pc_i            = pc;
        bus0.operand_a_i     = a;
        bus0.imm_i           = imm;
        bus0.cmp_res_i       = cmp;
        bus0.is_compressed_i = c;
        bus0.pred_taken_i    = pt;
        bus0.pred_addr_i     = pa;
    endtask

    task automatic send(input logic [1:0] op, input logic [63:0] pc, input logic [63:0] a,
                        input logic [63:0] imm, input logic cmp, input logic c,
                        input logic pt, input logic [63:0] pa);
        drive(op, pc, a, imm, cmp, c, pt, pa);
        @(posedge clk); #1;
        bus0.valid_i = 1'b0;
    endtask

    task automatic pop_one();
        bus0.res_ready_i = 1'b1;
        @(posedge clk); #1;
        bus0.res_ready_i = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        flush            = 1'b0;
        bus0.valid_i     = 1'b0;
        bus0.res_ready_i = 1'b0;
        bus0.pcc_base_i  = '0;
        bus0.pcc_top_i   = {1'b1, 64'h0};
        drive(2'd3, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        bus0.valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus0.res_valid_o, 0);
        check("rst_ready", bus0.ready_o, 1);
        check("rst_cnt", cnt0, 0);
        check("rst_target", bus0.res_target_o, 0);
        rst_n = 1'b1;

        // Taken branch, predicted not-taken
        send(2'd0, 64'h1000, 64'h0, 64'h20, 1'b1, 1'b0, 1'b0, 64'h0);
        check("br_valid", bus0.res_valid_o, 1);
        check("br_pc", bus0.res_pc_o, 64'h1000);
        check("br_target", bus0.res_target_o, 64'h1020);
        check("br_link", bus0.res_link_o, 64'h1004);
        check("br_taken", bus0.res_taken_o, 1);
        check("br_misp", bus0.res_mispredict_o, 1);
        check("br_exc", bus0.res_exc_o, 0);
        check("br_cnt", cnt0, 1);
        pop_one();
        check("br_popped", bus0.res_valid_o, 0);

        // JALR clears bit 0, correct prediction
        send(2'd2, 64'h3000, 64'h2001, 64'h0, 1'b0, 1'b0, 1'b1, 64'h2000);
        check("jalr_target", bus0.res_target_o, 64'h2000);
        check("jalr_link", bus0.res_link_o, 64'h3004);
        check("jalr_misp", bus0.res_mispredict_o, 0);
        check("jalr_exc", bus0.res_exc_o, 0);
        check("jalr_cnt", cnt0, 1);
        pop_one();

        // 2-byte aligned JAL: legal with RVC, misaligned without
        send(2'd1, 64'h1000, 64'h0, 64'h2, 1'b0, 1'b0, 1'b1, 64'h1002);
        check("jal_rvc_target", bus0.res_target_o, 64'h1002);
        check("jal_rvc_exc", bus0.res_exc_o, 0);
        check("jal_norvc_exc", bus1.res_exc_o, 1);
        pop_one();
        send(2'd1, 64'h1000, 64'h0, 64'h2, 1'b0, 1'b1, 1'b1, 64'h1002);
        check("jal_c_link", bus0.res_link_o, 64'h1002);
        check("jal_c_exc", bus0.res_exc_o, 0);
        pop_one();

        // JALR with wrong predicted address
        send(2'd2, 64'h6000, 64'h4000, 64'h10, 1'b0, 1'b0, 1'b1, 64'h4000);
        check("jalr_bad_target", bus0.res_target_o, 64'h4010);
        check("jalr_bad_misp", bus0.res_mispredict_o, 1);
        check("jalr_bad_cnt", cnt0, 2);
        pop_one();

        // Not-taken branch with odd offset: falls through, no exception
        send(2'd0, 64'h5000, 64'h0, 64'h3, 1'b0, 1'b0, 1'b1, 64'h0);
        check("br_nt_target", bus0.res_target_o, 64'h5004);
        check("br_nt_taken", bus0.res_taken_o, 0);
        check("br_nt_misp", bus0.res_mispredict_o, 1);
        check("br_nt_exc", bus0.res_exc_o, 0);
        check("br_nt_cnt", cnt0, 3);
        pop_one();

        // Address wrap-around on link and target
        send(2'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h8, 1'b0, 1'b0, 1'b1, 64'h4);
        check("wrap_link", bus0.res_link_o, 64'h0);
        check("wrap_target", bus0.res_target_o, 64'h4);
        check("wrap_misp", bus0.res_mispredict_o, 0);
        pop_one();

        // Reserved op is accepted but leaves nothing queued
        send(2'd3, 64'h7000, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
        check("nop_valid", bus0.res_valid_o, 0);
        check("nop_ready", bus0.ready_o, 1);
        check("nop_cnt", cnt0, 3);

        // Fill to DEPTH, hold a 5th, then drain in order
        for (int i = 1; i <= 4; i++) begin
            send(2'd1, 64'(i * 256), 64'h0, 64'h10, 1'b0, 1'b0, 1'b1, 64'h0);
        end
        check("full_ready", bus0.ready_o, 0);
        drive(2'd1, 64'h500, 64'h0, 64'h10, 1'b0, 1'b0, 1'b1, 64'h0);
        @(posedge clk); #1;
        check("full_held_ready", bus0.ready_o, 0);
        check("full_head0", bus0.res_pc_o, 64'h100);
        bus0.res_ready_i = 1'b1;
        @(posedge clk); #1;
        check("drain_head1", bus0.res_pc_o, 64'h200);
        check("drain_ready", bus0.ready_o, 1);
        @(posedge clk); #1;
        bus0.valid_i = 1'b0;
        check("drain_head2", bus0.res_pc_o, 64'h300);
        @(posedge clk); #1;
        check("drain_head3", bus0.res_pc_o, 64'h400);
        @(posedge clk); #1;
        check("drain_head5", bus0.res_pc_o, 64'h500);
        check("drain_t5", bus0.res_target_o, 64'h510);
        @(posedge clk); #1;
        check("drain_empty", bus0.res_valid_o, 0);
        bus0.res_ready_i = 1'b0;

        // Flush with a valid mispredicting op in the same cycle
        for (int i = 0; i < 3; i++) begin
            send(2'd1, 64'h8000 + 64'(i * 4), 64'h0, 64'h40, 1'b0, 1'b0, 1'b1, 64'h0);
        end
        check("pre_flush_cnt", cnt0, 3);
        drive(2'd1, 64'h9000, 64'h0, 64'h40, 1'b0, 1'b0, 1'b0, 64'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus0.valid_i = 1'b0;
        check("flush_valid", bus0.res_valid_o, 0);
        check("flush_ready", bus0.ready_o, 1);
        check("flush_cnt", cnt0, 3);
        check("flush_target", bus0.res_target_o, 0);
        send(2'd1, 64'hA000, 64'h0, 64'h8, 1'b0, 1'b0, 1'b0, 64'h0);
        check("post_flush_pc", bus0.res_pc_o, 64'hA000);
        check("post_flush_cnt", cnt0, 4);
        check("sat_cnt", cnt1, 3);
        pop_one();

`ifdef CHERI_PCC_BOUNDS_EN
        bus0.pcc_base_i = 64'h1000;
        bus0.pcc_top_i  = 65'h1100;
        send(2'd1, 64'h1000, 64'h0, 64'hFF, 1'b0, 1'b0, 1'b1, 64'h0);
        check("pcc_misalign", bus0.res_exc_o, 1);
        pop_one();
        send(2'd1, 64'h1000, 64'h0, 64'h100, 1'b0, 1'b0, 1'b1, 64'h0);
        check("pcc_over", bus0.res_exc_o, 2);
        pop_one();
        send(2'd1, 64'h1000, 64'h0, 64'hFE, 1'b0, 1'b0, 1'b1, 64'h0);
        check("pcc_edge", bus0.res_exc_o, 0);
        pop_one();
        bus0.pcc_base_i = '0;
        bus0.pcc_top_i  = {1'b1, 64'h0};
`endif

        // Reset mid-operation discards entries and clears the counter
        send(2'd1, 64'hB000, 64'h0, 64'h8, 1'b0, 1'b0, 1'b0, 64'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst2_valid", bus0.res_valid_o, 0);
        check("rst2_cnt", cnt0, 0);
        check("rst2_ready", bus0.ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
